// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: opcode enumeration, opcode width,
// flag bit positions and an opcode legality helper.
// Used by alu_pipe_core (combinational datapath) and alu_pipe (pipeline top).
// Optional feature macro: ALU_PIPE_FLAGS_EN (flags_o port and flag logic).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    // Opcode space: 0..10 assigned, 11..15 produce an illegal-op result.
    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SRL  = 4'd3,
        SRA  = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        EQ   = 4'd8,
        SLT  = 4'd9,
        SLTU = 4'd10
    } alu_op_e;

    // Bit positions inside the {V,C,N,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // True for every opcode that has a defined operation.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return (op <= 4'd10);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_pipe_core.sv
// -----------------------------------------------------------------------------
// alu_pipe_core
// Purely combinational ALU datapath sitting between the operand stage (S1) and
// the result stage (S2) of alu_pipe.
// Ports:
//   a_i, b_i   [WIDTH]  operands (shifts use b_i[SHW-1:0])
//   op_i       alu_op_e opcode
//   result_o   [WIDTH]  operation result (0 for unassigned opcodes)
//   illegal_o  1        opcode is unassigned
//   flags_o    [4]      {V,C,N,Z}; only built with ALU_PIPE_FLAGS_EN
// -----------------------------------------------------------------------------
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic [3:0]       flags_o
`endif
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    assign sh_s   = b_i[SHW-1:0];
    assign sum_s  = a_i + b_i;
    assign diff_s = a_i - b_i;

    // Opcode legality, independent of the result mux.
    assign illegal_o = ~alu_op_legal(op_i);

    // Result mux; compares are zero-extended single-bit results.
    always_comb begin
        result_o = {WIDTH{1'b0}};
        case (op_i)
            ADD:     result_o = sum_s;
            SUB:     result_o = diff_s;
            SLL:     result_o = a_i << sh_s;
            SRL:     result_o = a_i >> sh_s;
            SRA:     result_o = $signed(a_i) >>> sh_s;
            AND:     result_o = a_i & b_i;
            OR:      result_o = a_i | b_i;
            XOR:     result_o = a_i ^ b_i;
            EQ:      result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            SLT:     result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            SLTU:    result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: result_o = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic a_msb_s;
    logic b_msb_s;
    logic add_carry_s;
    logic add_ovf_s;
    logic sub_ovf_s;

    assign a_msb_s = a_i[WIDTH-1];
    assign b_msb_s = b_i[WIDTH-1];

    // Carry out of the top bit, recovered from operand and sum MSBs.
    assign add_carry_s = (a_msb_s & b_msb_s) | ((a_msb_s | b_msb_s) & ~sum_s[WIDTH-1]);
    // Overflow: like-signed operands for ADD (unlike for SUB) yielding a sign flip.
    assign add_ovf_s   = (a_msb_s == b_msb_s) & (sum_s[WIDTH-1]  != a_msb_s);
    assign sub_ovf_s   = (a_msb_s != b_msb_s) & (diff_s[WIDTH-1] != a_msb_s);

    // Status flags; all zero for unassigned opcodes.
    always_comb begin
        flags_o = 4'b0000;
        if (illegal_o) begin
            flags_o = 4'b0000;
        end else begin
            flags_o[FLAG_Z] = (result_o == {WIDTH{1'b0}});
            flags_o[FLAG_N] = result_o[WIDTH-1];
            case (op_i)
                ADD: begin
                    flags_o[FLAG_C] = add_carry_s;
                    flags_o[FLAG_V] = add_ovf_s;
                end
                SUB: begin
                    // C is the borrow: a < b unsigned.
                    flags_o[FLAG_C] = (a_i < b_i);
                    flags_o[FLAG_V] = sub_ovf_s;
                end
                default: begin
                    flags_o[FLAG_C] = 1'b0;
                    flags_o[FLAG_V] = 1'b0;
                end
            endcase
        end
    end
`endif

endmodule : alu_pipe_core

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes on input and output.
// S1 registers operands and opcode; S2 registers the alu_pipe_core result.
// Only handshake, pipeline registers and reset live here.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   in_valid_i/in_ready_o, a_i, b_i, op_i     operand side
//   out_valid_o/out_ready_i, result_o, illegal_op_o   result side
//   flags_o [4]       {V,C,N,Z}; present only with ALU_PIPE_FLAGS_EN
// Optional feature macro: ALU_PIPE_FLAGS_EN.
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [WIDTH-1:0]    result_o,
    output logic                illegal_op_o
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic [3:0]          flags_o
`endif
);

    // Stage 1: operand registers.
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    alu_op_e          s1_op_q,    s1_op_d;

    // Stage 2: result registers.
    logic             s2_valid_q,   s2_valid_d;
    logic [WIDTH-1:0] s2_result_q,  s2_result_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic             s1_adv_s;
    logic             in_ready_s;
    logic             s1_load_s;
    logic             s2_load_s;
    logic [WIDTH-1:0] core_result_s;
    logic             core_illegal_s;

`ifdef ALU_PIPE_FLAGS_EN
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [3:0]       core_flags_s;
`endif

    // S1 may hand over whenever S2 is empty or is being drained this cycle.
    assign s1_adv_s   = ~s2_valid_q | out_ready_i;
    assign in_ready_s = ~s1_valid_q | s1_adv_s;
    assign s1_load_s  = in_valid_i & in_ready_s;
    assign s2_load_s  = s1_valid_q & s1_adv_s;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .op_i      (s1_op_q),
        .result_o  (core_result_s),
        .illegal_o (core_illegal_s)
`ifdef ALU_PIPE_FLAGS_EN
        ,
        .flags_o   (core_flags_s)
`endif
    );

    // S1 next state: load on accept, empty when it hands over with no refill.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_load_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a_i;
            s1_b_d     = b_i;
            s1_op_d    = alu_op_e'(op_i);
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: load from S1, retire on out_ready_i, otherwise hold.
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_illegal_d = s2_illegal_q;
`ifdef ALU_PIPE_FLAGS_EN
        s2_flags_d   = s2_flags_q;
`endif
        if (s2_load_s) begin
            s2_valid_d   = 1'b1;
            s2_result_d  = core_result_s;
            s2_illegal_d = core_illegal_s;
`ifdef ALU_PIPE_FLAGS_EN
            s2_flags_d   = core_flags_s;
`endif
        end else if (out_ready_i) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; data is cleared on reset so outputs never go X.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= {WIDTH{1'b0}};
            s1_b_q       <= {WIDTH{1'b0}};
            s1_op_q      <= ADD;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= {WIDTH{1'b0}};
            s2_illegal_q <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
            s2_flags_q   <= 4'b0000;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_illegal_q <= s2_illegal_d;
`ifdef ALU_PIPE_FLAGS_EN
            s2_flags_q   <= s2_flags_d;
`endif
        end
    end

    assign in_ready_o   = in_ready_s;
    assign out_valid_o  = s2_valid_q;
    assign result_o     = s2_result_q;
    assign illegal_op_o = s2_illegal_q;
`ifdef ALU_PIPE_FLAGS_EN
    assign flags_o      = s2_flags_q;
`endif

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed self-checking bench for alu_pipe (WIDTH=8). Flag comparisons are
// included when ALU_PIPE_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [3:0]       op_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             illegal_op_o;
`ifdef ALU_PIPE_FLAGS_EN
    logic [3:0]       flags_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .op_i         (op_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .result_o     (result_o),
        .illegal_op_o (illegal_op_o)
`ifdef ALU_PIPE_FLAGS_EN
        ,
        .flags_o      (flags_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation through an empty pipe with out_ready_i=1.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic exp_ill, input logic [3:0] exp_flags);
        a_i        = a;
        b_i        = b;
        op_i       = op;
        in_valid_i = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk({tag, "_not_yet"}, out_valid_o, 0);
        tick();
        chk({tag, "_valid"}, out_valid_o, 1);
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_illegal"}, illegal_op_o, exp_ill);
`ifdef ALU_PIPE_FLAGS_EN
        chk({tag, "_flags"}, flags_o, exp_flags);
`else
        if (exp_flags === 4'bxxxx) $display("note: undefined flag expectation for %s", tag);
`endif
        tick();
        chk({tag, "_retired"}, out_valid_o, 0);
    endtask

    initial begin
        int  idx;
        int  nout;
        logic rdy;

        reset_n     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        a_i         = 8'h00;
        b_i         = 8'h00;
        op_i        = 4'd0;
        tick();
        tick();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_illegal", illegal_op_o, 0);
`ifdef ALU_PIPE_FLAGS_EN
        chk("rst_flags", flags_o, 0);
`endif
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready_o, 1);
        chk("post_rst_out_valid", out_valid_o, 0);

        // Flags are {V,C,N,Z}.
        run_op("add_carry", 4'd0,  8'hF0, 8'h20, 8'h10, 1'b0, 4'b0100);
        run_op("sub_ovf",   4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 4'b1000);
        run_op("slt",       4'd9,  8'hFF, 8'h01, 8'h01, 1'b0, 4'b0000);
        run_op("sltu",      4'd10, 8'hFF, 8'h01, 8'h00, 1'b0, 4'b0001);
        run_op("sra",       4'd4,  8'h90, 8'h0B, 8'hF2, 1'b0, 4'b0010);
        run_op("srl",       4'd3,  8'h90, 8'h0B, 8'h12, 1'b0, 4'b0000);
        run_op("sll",       4'd2,  8'h01, 8'h07, 8'h80, 1'b0, 4'b0010);
        run_op("and",       4'd5,  8'hA5, 8'h0F, 8'h05, 1'b0, 4'b0000);
        run_op("or",        4'd6,  8'hA5, 8'h0F, 8'hAF, 1'b0, 4'b0010);
        run_op("xor",       4'd7,  8'hA5, 8'h0F, 8'hAA, 1'b0, 4'b0010);
        run_op("add_wrap",  4'd0,  8'hFF, 8'h01, 8'h00, 1'b0, 4'b0101);
        run_op("sub_borrow",4'd1,  8'h01, 8'h02, 8'hFF, 1'b0, 4'b0110);
        run_op("illegal_c", 4'hC,  8'h12, 8'h34, 8'h00, 1'b1, 4'b0000);
        run_op("eq",        4'd8,  8'h55, 8'h55, 8'h01, 1'b0, 4'b0000);

        // Stall: five ADDs offered with out_ready_i low; only two fit.
        out_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid_i = 1'b1;
            a_i        = 8'(idx + 1);
            b_i        = 8'h10;
            op_i       = 4'd0;
            #1;
            rdy = in_ready_o;
            tick();
            if (rdy) idx++;
        end
        chk("stall_accepts", idx, 2);
        chk("stall_in_ready", in_ready_o, 0);
        chk("stall_valid", out_valid_o, 1);
        chk("stall_result", result_o, 8'h11);
        tick();
        tick();
        chk("stall_hold_valid", out_valid_o, 1);
        chk("stall_hold_result", result_o, 8'h11);

        // Release: results must come out in order on consecutive cycles.
        out_ready_i = 1'b1;
        nout = 0;
        for (int c = 0; c < 12 && nout < 5; c++) begin
            in_valid_i = (idx < 5);
            a_i        = 8'(idx + 1);
            b_i        = 8'h10;
            op_i       = 4'd0;
            #1;
            if (out_valid_o) begin
                chk("stream_result", result_o, 8'h11 + nout);
                chk("stream_cycle", c, nout);
                nout++;
            end
            rdy = in_ready_o;
            tick();
            if (rdy && in_valid_i) idx++;
        end
        in_valid_i = 1'b0;
        chk("stream_count", nout, 5);
        tick();
        chk("stream_drained", out_valid_o, 0);

        // Fill both stages, then reset mid-stream.
        out_ready_i = 1'b0;
        a_i         = 8'h33;
        b_i         = 8'h44;
        op_i        = 4'd0;
        in_valid_i  = 1'b1;
        tick();
        tick();
        tick();
        chk("full_in_ready", in_ready_o, 0);
        chk("full_valid", out_valid_o, 1);
        reset_n    = 1'b0;
        in_valid_i = 1'b0;
        tick();
        chk("midrst_out_valid", out_valid_o, 0);
        chk("midrst_in_ready", in_ready_o, 1);
        chk("midrst_result", result_o, 0);
        reset_n     = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no_stale", out_valid_o, 0);
        end
        run_op("after_rst", 4'd0, 8'h01, 8'h02, 8'h03, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_pipe

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both sides, a 4-bit opcode space (signed/unsigned compares, arithmetic shift) and optional status flags. It sits between an operand producer (register-file read or test sequencer) and a result consumer. It replaces the 8-bit single-cycle combinational ALU where throughput, backpressure or widths other than 8 bits are needed.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_valid_i  input  1  operands and op presented.
- in_ready_o  output  1  block accepts this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B; shifts use b_i[SHW-1:0].
- op_i  input  4  opcode, alu_pkg::alu_op_e.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  result.
- flags_o  output  4  {V,C,N,Z}; present only with ALU_PIPE_FLAGS_EN.
- illegal_op_o  output  1  result came from an unassigned opcode.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 SLL a<<sh; 3 SRL logical a>>sh; 4 SRA arithmetic a>>>sh; 5 AND; 6 OR; 7 XOR; 8 EQ; 9 SLT signed a<b; 10 SLTU unsigned a<b. Compare results are zero-extended 1-bit values.
- Opcodes 11..15: result 0, illegal_op_o=1 for that result, flags 0.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Stage 1 (S1) registers a, b and op on a handshake. Stage 2 (S2) computes from the S1 registers and registers the result, flags and illegal_op.
- Handshake: a transfer occurs when valid && ready on the same edge. in_ready_o = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready_i. in_ready_o does not depend on in_valid_i.
- S2 loads when s1_valid && s1_adv. S2 clears valid on out_ready_i when it has no new load.
- out_valid_o, result_o, flags_o and illegal_op_o hold stable while out_valid_o && !out_ready_i.
- Flags (ALU_PIPE_FLAGS_EN):
  - Z = result==0.
  - N = result[WIDTH-1].
  - C = carry-out (ADD) or borrow, i.e. a<b unsigned (SUB); 0 otherwise.
  - V = signed overflow (ADD/SUB only); 0 otherwise.
- Ordering is strictly in order. No result is dropped or duplicated.

## Timing
- Latency: accept at edge k gives out_valid_o=1 after edge k+1 (2 register stages), with no stall.
- Throughput: 1 result/cycle while out_ready_i=1.
- Full: both stages valid and out_ready_i=0 gives in_ready_o=0. A single cycle of out_ready_i=1 moves S1 to S2 and accepts a new input on the same edge.
- Empty: out_valid_o=0 and in_ready_o=1.
- Simultaneous accept and retire on the same edge is required to sustain full rate.
- Reset (reset_n=0 at an edge): s1_valid=0, s2_valid=0, out_valid_o=0, result_o=0, flags_o=0, illegal_op_o=0.
  - in_ready_o=1 from the first cycle after reset.
  - Reset mid-stream discards all in-flight operations without output.
- Data registers are reset as well, so outputs are never X.

## Configuration
- ALU_PIPE_FLAGS_EN defined: the flags_o port exists and flag logic is built as specified.
- Not defined: the flags_o port and flag logic are absent, and all other behaviour is identical.

## Structure
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e, with the opcode names above;
  - localparam ALU_OP_W = 4;
  - flag bit-index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- Sub-module alu_pipe_core: purely combinational, parametrised by WIDTH. Inputs are a, b and op. Outputs are result, flags and illegal. It is instantiated between S1 and S2.
- alu_pipe contains only the handshake, pipeline registers and reset.

## Test plan
- WIDTH=8, ADD a=8'hF0 b=8'h20, out_ready_i=1 -> result 8'h10, C=1, V=0, Z=0, out_valid_o two edges after accept.
- SUB a=8'h80 b=8'h01 -> 8'h7F, V=1, C=0. SLT 8'hFF vs 8'h01 -> 1. SLTU 8'hFF vs 8'h01 -> 0.
- SRA a=8'h90 b=8'h0B (sh=3) -> 8'hF2. SRL with the same operands -> 8'h12. SLL a=8'h01 sh=7 -> 8'h80.
- Stream of 5 ADDs with out_ready_i held 0 -> in_ready_o drops after 2 accepts and outputs stay stable. Release -> 5 results in order, back-to-back.
- op=4'hC -> result 0, illegal_op_o=1. Next op EQ 8'h55 vs 8'h55 -> 1, illegal_op_o=0.
- reset_n=0 with both stages full -> next cycle out_valid_o=0, in_ready_o=1, and no stale result ever appears.
